booth_radix4_multiplier: RTL and testbench

Parametrised radix-4 Booth multiplier: the next generation of the team's 8-bit low-power Booth unit. Accepts two WIDTH-bit operands (signed or unsigned) over a valid/ready handshake. Retires two multiplier bits per cycle, with power-mode-selected early termination and zero-operand bypass. Holds the product until the consumer accepts it. Runs on the gated clock domain behind the clock-gating cell, alongside the power-monitoring logic.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_r4_digit_enc.sv | 20 ++
 rtl/booth_radix4_multiplier.sv | 140 ++++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   state_e        : control FSM states
//   PM_*           : power_mode encodings (bit 1 enables zero-operand bypass)
//   booth_digit_t  : recoded digit {neg, two, zero}
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] PM_NORMAL = 2'b00;
  localparam logic [1:0] PM_EARLY  = 2'b01;
  localparam logic [1:0] PM_ULTRA  = 2'b10;

  typedef struct packed {
    logic neg;   // subtract the partial product
    logic two;   // partial product is 2*M
    logic zero;  // digit is 0, no accumulator write
  } booth_digit_t;

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: maps triplet {q[2i+1], q[2i], q[2i-1]} to a digit
// in {0, +-1, +-2}.
//   trip_i : multiplier triplet
//   dig_o  : {neg, two, zero}
module booth_r4_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]   trip_i,
  output booth_digit_t dig_o
);

  always_comb begin
    dig_o      = '0;
    dig_o.zero = (trip_i == 3'b000) || (trip_i == 3'b111);
    dig_o.two  = (trip_i == 3'b011) || (trip_i == 3'b100);
    // Negative for 100/101/110; 111 is zero so neg is suppressed there.
    dig_o.neg  = trip_i[2] && !(trip_i[1] && trip_i[0]);
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional feature macro: BOOTH_ACTIVITY_EN builds the non-zero digit counter;
// without it activity is tied to 0.
// Ports:
//   gated_clk, reset (async, active-high)
//   in_valid/in_ready, multiplicand, multiplier, signed_mode, power_mode
//   out_valid/out_ready, product (low 2*WIDTH bits), cycles (CALC cycles),
//   activity (non-zero digits, saturating)
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 8,
  localparam int ITER  = WIDTH / 2 + 1,
  localparam int CYC_W = $clog2(ITER + 1)
) (
  input  logic               gated_clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  input  logic [1:0]         power_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [CYC_W-1:0]   cycles,
  output logic [CNT_W-1:0]   activity
);

  localparam int XW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 2;

  state_e             state_q;
  logic [AW-1:0]      m_sh_q;   // M * 4^i, shifted left 2 per digit
  logic [XW:0]        q_q;      // extended Q with implicit 0 below, shifts right 2
  logic [AW-1:0]      acc_q;
  logic [CYC_W-1:0]   cnt_q;
  logic [1:0]         pm_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] product_q;
  logic [CYC_W-1:0]   cycles_q;

  booth_digit_t  dig;
  logic [AW-1:0] pp, sum;
  logic          early, last, bypass;
  logic [XW-1:0] m_ext;

  function automatic logic [XW-1:0] ext(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  booth_r4_digit_enc u_enc (
    .trip_i (q_q[2:0]),
    .dig_o  (dig)
  );

  assign m_ext  = ext(multiplicand, signed_mode);
  assign pp     = dig.two ? {m_sh_q[AW-2:0], 1'b0} : m_sh_q;
  assign sum    = dig.neg ? acc_q - pp : acc_q + pp;
  // Bits above the current triplet all equal => every remaining digit is 0.
  // Arithmetic shifting replicates the top bit, so checking the whole upper
  // field of the shift register is exact.
  assign early  = (q_q[XW:2] == '0) || (q_q[XW:2] == '1);
  assign last   = ((pm_q != PM_NORMAL) && early) || (cnt_q == CYC_W'(ITER - 1));
  assign bypass = power_mode[1] && ((multiplicand == '0) || (multiplier == '0));

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      m_sh_q      <= '0;
      q_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pm_q        <= PM_NORMAL;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      cycles_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          m_sh_q  <= {{(AW - XW){m_ext[XW-1]}}, m_ext};
          q_q     <= {ext(multiplier, signed_mode), 1'b0};
          acc_q   <= '0;
          cnt_q   <= '0;
          pm_q    <= power_mode;
          state_q <= bypass ? DONE : CALC;
        end
        CALC: begin
          if (!dig.zero) acc_q <= sum;
          m_sh_q <= m_sh_q << 2;
          q_q    <= {{2{q_q[XW]}}, q_q[XW:2]};
          cnt_q  <= cnt_q + 1'b1;
          if (last) state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; it then holds until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            product_q   <= acc_q[2*WIDTH-1:0];
            cycles_q    <= cnt_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign cycles    = cycles_q;

`ifdef BOOTH_ACTIVITY_EN
  logic [CNT_W-1:0] act_q, activity_q;

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      act_q      <= '0;
      activity_q <= '0;
    end else begin
      if (state_q == IDLE && in_valid)
        act_q <= '0;
      else if (state_q == CALC && !dig.zero && act_q != '1)
        act_q <= act_q + 1'b1;
      if (state_q == DONE && !out_valid_q)
        activity_q <= act_q;
    end
  end

  assign activity = activity_q;
`else
  assign activity = '0;
`endif

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
module tb_booth_radix4_multiplier;

  logic        gated_clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  multiplicand, multiplier;
  logic        signed_mode;
  logic [1:0]  power_mode;
  logic        out_valid, out_ready;
  logic [15:0] product;
  logic [2:0]  cycles;
  logic [7:0]  activity;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 gated_clk = ~gated_clk;

  booth_radix4_multiplier #(.WIDTH(8), .CNT_W(8)) dut (
    .gated_clk    (gated_clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .signed_mode  (signed_mode),
    .power_mode   (power_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .cycles       (cycles),
    .activity     (activity)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ea(input int n);
`ifdef BOOTH_ACTIVITY_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Present one operation, measure edges from transfer to out_valid, check
  // the result and, if out_ready is high, the return to IDLE.
  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic sg, input logic [1:0] pm, input logic [15:0] ep,
                        input int ec, input int eact, input int elat);
    int lat;
    @(negedge gated_clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    multiplicand = m; multiplier = q; signed_mode = sg; power_mode = pm;
    in_valid = 1'b1;
    @(posedge gated_clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge gated_clk);
      #1 lat++;
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".product"}, product, ep);
    chk({tag, ".cycles"}, cycles, ec);
    chk({tag, ".activity"}, activity, ea(eact));
    if (out_ready) begin
      @(posedge gated_clk);
      #1;
      chk({tag, ".idle_rdy"}, in_ready, 1);
      chk({tag, ".idle_vld"}, out_valid, 0);
    end
  endtask

  initial begin
    logic [15:0] held;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    multiplicand = '0; multiplier = '0; signed_mode = 1'b0; power_mode = 2'b00;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.product", product, 0);
    chk("rst.cycles", cycles, 0);
    chk("rst.activity", activity, 0);
    #22 reset = 1'b0;

    run_op("neg5x3_m00",  8'hFB, 8'd3,   1'b1, 2'b00, 16'hFFF1, 5, 2, 6);
    run_op("neg5x3_m01",  8'hFB, 8'd3,   1'b1, 2'b01, 16'hFFF1, 2, 2, 3);
    run_op("u255sq_m01",  8'hFF, 8'hFF,  1'b0, 2'b01, 16'hFE01, 5, 2, 6);
    run_op("neg1sq_m01",  8'hFF, 8'hFF,  1'b1, 2'b01, 16'h0001, 1, 1, 2);
    run_op("byp0x77_m10", 8'd0,  8'd77,  1'b1, 2'b10, 16'h0000, 0, 0, 1);
    run_op("byp0xm3_m11", 8'd0,  8'hFD,  1'b1, 2'b11, 16'h0000, 0, 0, 1);
    run_op("noby7x0_m01", 8'd7,  8'd0,   1'b1, 2'b01, 16'h0000, 1, 0, 2);

    // Held result: consumer stalls for 10 cycles.
    out_ready = 1'b0;
    run_op("stall12x10", 8'd12, 8'd10, 1'b0, 2'b00, 16'h0078, 5, 3, 6);
    held = product;
    for (int i = 0; i < 10; i++) begin
      @(negedge gated_clk);
      in_valid = i[0]; multiplicand = 8'd3; multiplier = 8'd9;
      chk("stall.product", product, held);
      chk("stall.in_ready", in_ready, 0);
      chk("stall.out_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge gated_clk);
    #1;
    chk("stall.release_rdy", in_ready, 1);
    chk("stall.release_vld", out_valid, 0);
    chk("stall.product_kept", product, 16'h0078);

    // Reset during the second CALC cycle.
    @(negedge gated_clk);
    multiplicand = 8'd100; multiplier = 8'd3; signed_mode = 1'b1; power_mode = 2'b00;
    in_valid = 1'b1;
    @(posedge gated_clk);
    #1 in_valid = 1'b0;
    @(posedge gated_clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.product", product, 0);
    chk("midrst.cycles", cycles, 0);
    chk("midrst.activity", activity, 0);
    @(negedge gated_clk);
    reset = 1'b0;
    run_op("after_rst_7xm8", 8'd7, 8'hF8, 1'b1, 2'b00, 16'hFFC8, 5, 1, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
